// File: rtl/uart_sched_pkg.sv
// Shared constants and types for the UART scheduling controller: register map,
// STAT/CTRL bit positions and the TX sequencing FSM states.
package uart_sched_pkg;

  localparam int unsigned ByteW = 8;

  // Word offsets, decoded from wbs_adr_i[3:2]
  localparam logic [1:0] RegRxData = 2'd0;
  localparam logic [1:0] RegTxData = 2'd1;
  localparam logic [1:0] RegStat   = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  localparam int unsigned StatRxNonempty = 0;
  localparam int unsigned StatRxFull     = 1;
  localparam int unsigned StatTxEmpty    = 2;
  localparam int unsigned StatTxFull     = 3;
  localparam int unsigned StatTxActive   = 4;
  localparam int unsigned StatRxOvr      = 5;
  localparam int unsigned StatTxOvf      = 6;
  localparam int unsigned StatW          = 7;

  localparam int unsigned CtrlRxIrqEn = 0;
  localparam int unsigned CtrlTxIrqEn = 1;
  localparam int unsigned CtrlW       = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StDrain
  } tx_state_e;

endpackage

// File: rtl/uart_sched_fifo.sv
// Byte FIFO with occupancy counter; a push on a full FIFO is accepted only when
// a pop happens in the same cycle, otherwise it is dropped and flagged.
module uart_sched_fifo
  import uart_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [ByteW-1:0] wdata_i,
  input  logic             pop_i,
  output logic [ByteW-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [ByteW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign drop_o  = push_i & ~push_ok;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_sched_ctrl.sv
// Wishbone-slave UART scheduler: TX FIFO feeding the TX engine via start/busy,
// RX FIFO capturing engine bytes, sticky error flags and a registered IRQ.
module uart_sched_ctrl
  import uart_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             tx_start,
  output logic [ByteW-1:0] tx_data,
  input  logic             tx_busy,
  input  logic             rx_valid,
  input  logic [ByteW-1:0] rx_data,
  output logic             irq
);

  logic             sel;
  logic             ack_q, ack_d;
  logic [1:0]       req_reg_q;
  logic             req_we_q;
  logic             req_sel0_q;
  logic [ByteW-1:0] req_dat_q;

  logic             wr_cycle, rd_cycle;
  logic             rx_pop, tx_push, stat_wr, ctrl_wr;

  logic [ByteW-1:0] rx_head, tx_head;
  logic             rx_full, rx_empty, rx_drop;
  logic             tx_full, tx_empty, tx_drop;
  logic             tx_pop;

  tx_state_e        state_q, state_d;
  logic [ByteW-1:0] tx_data_q, tx_data_d;
  logic             rx_ovr_q, rx_ovr_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  logic             irq_q, irq_d;
  logic [StatW-1:0] stat;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{wbs_adr_i[11:4], wbs_adr_i[1:0], wbs_dat_i[31:ByteW], wbs_sel_i[3:1]};

  assign sel   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  // Blocking a second ack right after the first forces a fresh sel per transfer
  assign ack_d = sel & ~ack_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      req_reg_q  <= '0;
      req_we_q   <= 1'b0;
      req_sel0_q <= 1'b0;
      req_dat_q  <= '0;
    end else begin
      ack_q <= ack_d;
      if (ack_d) begin
        req_reg_q  <= wbs_adr_i[3:2];
        req_we_q   <= wbs_we_i;
        req_sel0_q <= wbs_sel_i[0];
        req_dat_q  <= wbs_dat_i[ByteW-1:0];
      end
    end
  end

  // All register side effects happen only in the ack cycle
  assign wr_cycle = ack_q & req_we_q;
  assign rd_cycle = ack_q & ~req_we_q;
  assign rx_pop   = rd_cycle & (req_reg_q == RegRxData) & ~rx_empty;
  assign tx_push  = wr_cycle & (req_reg_q == RegTxData) & req_sel0_q;
  assign stat_wr  = wr_cycle & (req_reg_q == RegStat);
  assign ctrl_wr  = wr_cycle & (req_reg_q == RegCtrl);

  uart_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (rx_valid),
    .wdata_i (rx_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .drop_o  (rx_drop)
  );

  uart_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (tx_push),
    .wdata_i (req_dat_q),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .drop_o  (tx_drop)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!tx_empty) begin
          tx_pop    = 1'b1;
          tx_data_d = tx_head;
          state_d   = StStart;
        end
      end
      // A busy engine at entry still counts as acceptance of the byte
      StStart: if (tx_busy) state_d = StDrain;
      StDrain: if (!tx_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign tx_start = (state_q == StStart);
  assign tx_data  = tx_data_q;

  // A new error event wins over a simultaneous write-1-to-clear
  always_comb begin
    rx_ovr_d = rx_drop | (rx_ovr_q & ~(stat_wr & req_dat_q[StatRxOvr]));
    tx_ovf_d = tx_drop | (tx_ovf_q & ~(stat_wr & req_dat_q[StatTxOvf]));
    ctrl_d   = ctrl_wr ? req_dat_q[CtrlW-1:0] : ctrl_q;
    irq_d    = (ctrl_q[CtrlRxIrqEn] & ~rx_empty)
             | (ctrl_q[CtrlTxIrqEn] & tx_empty & (state_q == StIdle) & ~tx_busy)
             | rx_ovr_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      tx_data_q <= '0;
      rx_ovr_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      ctrl_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      rx_ovr_q  <= rx_ovr_d;
      tx_ovf_q  <= tx_ovf_d;
      ctrl_q    <= ctrl_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    stat                 = '0;
    stat[StatRxNonempty] = ~rx_empty;
    stat[StatRxFull]     = rx_full;
    stat[StatTxEmpty]    = tx_empty;
    stat[StatTxFull]     = tx_full;
    stat[StatTxActive]   = (state_q != StIdle);
    stat[StatRxOvr]      = rx_ovr_q;
    stat[StatTxOvf]      = tx_ovf_q;
  end

  always_comb begin
    rdata = '0;
    if (rd_cycle) begin
      unique case (req_reg_q)
        RegRxData: if (!rx_empty) rdata[ByteW-1:0] = rx_head;
        RegStat:   rdata[StatW-1:0] = stat;
        RegCtrl:   rdata[CtrlW-1:0] = ctrl_q;
        default:   rdata = '0;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata;

endmodule

// File: tb/tb_uart_sched_ctrl.sv
// Self-checking bench for uart_sched_ctrl: register table, directed corner cases,
// and a randomized phase against a queue-based model of the FIFOs and flags.
module tb_uart_sched_ctrl;

  localparam logic [31:0] Base   = 32'h3000_0000;
  localparam logic [31:0] AdrRx  = Base + 32'h0;
  localparam logic [31:0] AdrTx  = Base + 32'h4;
  localparam logic [31:0] AdrSt  = Base + 32'h8;
  localparam logic [31:0] AdrCt  = Base + 32'hC;
  localparam int          Depth  = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Engine model controls and captured bytes
  int         eng_len = 2;   // 0 selects a random frame length
  bit         eng_off = 1'b0;
  int         eng_cnt = 0;
  bit         eng_pend = 1'b0;
  logic [7:0] got[$];

  typedef struct {
    int          op;         // 0 write, 1 read+compare, 2 expect no ack
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] exp3[5];
  logic [7:0] rx_m[$];
  logic [7:0] tx_m[$];

  uart_sched_ctrl #(
    .FIFO_DEPTH (Depth),
    .BASE_ADDR  (Base)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .irq       (irq)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Engine: sees tx_start, raises busy one cycle later, holds it for the frame
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i || eng_off) begin
        tx_busy  = 1'b0;
        eng_cnt  = 0;
        eng_pend = 1'b0;
      end else if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 0) tx_busy = 1'b0;
      end else if (eng_pend) begin
        eng_pend = 1'b0;
        tx_busy  = 1'b1;
        eng_cnt  = (eng_len == 0) ? int'($urandom_range(1, 6)) : eng_len;
        got.push_back(tx_data);
      end else if (tx_start) begin
        eng_pend = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the ack cycle (or after timeout)
  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit rx_on_ack, input logic [7:0] rx_b,
                          output logic [31:0] rdat, output bit acked);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    acked = 1'b0;
    rdat  = '0;
    for (int i = 0; i < 6 && !acked; i++) begin
      @(posedge wb_clk_i);
      #1;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (rx_on_ack && acked) begin
      rx_valid = 1'b1;
      rx_data  = rx_b;
      idle(1);
      rx_valid = 1'b0;
    end
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    bit a;
    wb_cycle(1'b1, adr, dat, sel, 1'b0, 8'h00, r, a);
    check("write ack", 32'(a), 32'd1);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] r);
    bit a;
    wb_cycle(1'b0, adr, 32'h0, 4'hF, 1'b0, 8'h00, r, a);
    check("read ack", 32'(a), 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    wb_rd(adr, r);
    check(name, r, exp);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    idle(1);
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    bit          a;
    bit          flag;
    int          n;
    int          pushed;
    bit          ovr_m, rxen_m;

    vecs[0]  = '{1, AdrSt, 32'h0,         4'hF, 32'h4};
    vecs[1]  = '{1, AdrCt, 32'h0,         4'hF, 32'h0};
    vecs[2]  = '{0, AdrCt, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[3]  = '{1, AdrCt, 32'h0,         4'hF, 32'h3};
    vecs[4]  = '{1, AdrTx, 32'h0,         4'hF, 32'h0};
    vecs[5]  = '{1, AdrRx, 32'h0,         4'hF, 32'h0};
    vecs[6]  = '{0, AdrRx, 32'h55,        4'hF, 32'h0};
    vecs[7]  = '{1, AdrSt, 32'h0,         4'hF, 32'h4};
    vecs[8]  = '{0, AdrCt, 32'h0,         4'hF, 32'h0};
    vecs[9]  = '{0, AdrTx, 32'h77,        4'hE, 32'h0};
    vecs[10] = '{1, AdrSt, 32'h0,         4'hF, 32'h4};
    vecs[11] = '{2, Base + 32'h1008, 32'h0, 4'hF, 32'h0};
    vecs[12] = '{2, 32'h2000_0008,   32'h0, 4'hF, 32'h0};
    exp3 = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};

    // Reset state
    idle(3);
    check("reset tx_start", 32'(tx_start), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    check("reset ack", 32'(wbs_ack_o), 32'd0);
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    idle(1);

    // Register table
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].op == 0) begin
        wb_wr(vecs[i].adr, vecs[i].wdat, vecs[i].sel);
      end else if (vecs[i].op == 1) begin
        wb_rd(vecs[i].adr, r);
        check($sformatf("table[%0d] rdata", i), r, vecs[i].exp);
      end else begin
        wb_cycle(1'b0, vecs[i].adr, 32'h0, vecs[i].sel, 1'b0, 8'h00, r, a);
        check($sformatf("table[%0d] no ack outside window", i), 32'(a), 32'd0);
      end
    end

    // TX irq term, and ack never back-to-back with dat_o zero outside ack
    wb_wr(AdrCt, 32'h2, 4'hF);
    idle(2);
    check("tx irq when idle", 32'(irq), 32'd1);
    wb_wr(AdrCt, 32'h0, 4'hF);
    idle(2);
    check("tx irq cleared", 32'(irq), 32'd0);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = AdrSt; wbs_sel_i = 4'hF;
    n = 0;
    flag = 1'b0;
    repeat (4) begin
      idle(1);
      if (wbs_ack_o) n++;
      else if (wbs_dat_o != 32'h0) flag = 1'b1;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    idle(1);
    check("ack count over 4 held cycles", 32'(n), 32'd2);
    check("dat_o zero outside ack", 32'(flag), 32'd0);

    // Single byte through the engine
    got.delete();
    eng_len = 100;
    wb_wr(AdrTx, 32'h3D, 4'hF);
    for (int i = 0; i < 10 && !tx_start; i++) idle(1);
    check("t2 tx_start rises", 32'(tx_start), 32'd1);
    check("t2 tx_data", 32'(tx_data), 32'h3D);
    flag = 1'b0;
    for (int i = 0; i < 10 && !tx_busy; i++) begin
      if (!tx_start) flag = 1'b1;
      idle(1);
    end
    check("t2 busy seen", 32'(tx_busy), 32'd1);
    check("t2 start held until busy", 32'(flag), 32'd0);
    check("t2 start dropped after busy", 32'(tx_start), 32'd0);
    rd_chk("t2 stat active", AdrSt, 32'h14);
    for (int i = 0; i < 200 && tx_busy; i++) idle(1);
    idle(2);
    rd_chk("t2 stat idle", AdrSt, 32'h4);
    check("t2 bytes sent", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("t2 byte", 32'(got[0]), 32'h3D);

    // TX overflow while the engine is busy
    got.delete();
    eng_len = 150;
    wb_wr(AdrTx, 32'hAA, 4'hF);
    for (int i = 0; i < 20 && !tx_busy; i++) idle(1);
    idle(1);
    for (int i = 1; i <= 5; i++) wb_wr(AdrTx, 32'(i), 4'hF);
    rd_chk("t3 stat full+ovf", AdrSt, 32'h58);
    wb_wr(AdrSt, 32'h40, 4'hF);
    rd_chk("t3 stat ovf cleared", AdrSt, 32'h18);
    eng_len = 3;
    for (int i = 0; i < 500 && got.size() < 5; i++) idle(1);
    idle(10);
    check("t3 bytes sent", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check($sformatf("t3 byte %0d", i), 32'(got[i]), 32'(exp3[i]));

    // RX irq and read
    wb_wr(AdrCt, 32'h1, 4'hF);
    pulse_rx(8'h0F);
    for (int i = 0; i < 2 && !irq; i++) idle(1);
    check("t4 irq on rx", 32'(irq), 32'd1);
    rd_chk("t4 rx read", AdrRx, 32'h0F);
    idle(2);
    check("t4 irq after read", 32'(irq), 32'd0);
    rd_chk("t4 rx read empty", AdrRx, 32'h0);

    // RX overrun, then coincident pop and push on a full FIFO
    wb_wr(AdrCt, 32'h0, 4'hF);
    for (int i = 1; i <= 5; i++) pulse_rx(8'hA0 + 8'(i));
    idle(1);
    check("t5 irq on overrun", 32'(irq), 32'd1);
    rd_chk("t5 stat overrun", AdrSt, 32'h27);
    wb_wr(AdrSt, 32'h20, 4'hF);
    idle(2);
    check("t5 irq after clear", 32'(irq), 32'd0);
    rd_chk("t5 stat after clear", AdrSt, 32'h07);
    for (int i = 1; i <= 4; i++) rd_chk("t5 rx drain", AdrRx, 32'hA0 + 32'(i));
    for (int i = 1; i <= 4; i++) pulse_rx(8'hB0 + 8'(i));
    wb_cycle(1'b0, AdrRx, 32'h0, 4'hF, 1'b1, 8'hC5, r, a);
    check("t5 coincident read", r, 32'hB1);
    rd_chk("t5 stat no overrun", AdrSt, 32'h07);
    for (int i = 2; i <= 4; i++) rd_chk("t5 rx order", AdrRx, 32'hB0 + 32'(i));
    rd_chk("t5 rx coincident byte", AdrRx, 32'hC5);
    rd_chk("t5 stat empty", AdrSt, 32'h4);

    // Asynchronous reset while in START
    eng_off = 1'b1;
    wb_wr(AdrCt, 32'h1, 4'hF);
    pulse_rx(8'h11);
    wb_wr(AdrTx, 32'h99, 4'hF);
    for (int i = 0; i < 10 && !tx_start; i++) idle(1);
    idle(1);
    check("t6 start before reset", 32'(tx_start), 32'd1);
    check("t6 irq before reset", 32'(irq), 32'd1);
    @(posedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("t6 tx_start async drop", 32'(tx_start), 32'd0);
    check("t6 irq async drop", 32'(irq), 32'd0);
    idle(2);
    wb_rst_i = 1'b0;
    eng_off  = 1'b0;
    idle(1);
    rd_chk("t6 stat after reset", AdrSt, 32'h4);

    // Randomized phase against a queue model
    got.delete();
    eng_len = 0;
    pushed  = 0;
    ovr_m   = 1'b0;
    rxen_m  = 1'b0;
    rx_m.delete();
    tx_m.delete();
    for (int it = 0; it < 300; it++) begin
      int          op;
      logic [7:0]  b;
      logic [31:0] v;
      logic [31:0] e;
      op = int'($urandom_range(0, 5));
      b  = 8'($urandom);
      v  = $urandom;
      case (op)
        0: begin
          pulse_rx(b);
          if (rx_m.size() < Depth) rx_m.push_back(b);
          else ovr_m = 1'b1;
        end
        1: begin
          e = (rx_m.size() != 0) ? 32'(rx_m.pop_front()) : 32'h0;
          rd_chk("rand rx read", AdrRx, e);
        end
        2: begin
          e = {25'h0, 1'b0, ovr_m, 3'b000, (rx_m.size() == Depth), (rx_m.size() != 0)};
          wb_rd(AdrSt, r);
          check("rand stat", r & 32'h63, e);
        end
        3: begin
          if (pushed - got.size() < Depth) begin
            wb_wr(AdrTx, 32'(b), 4'hF);
            tx_m.push_back(b);
            pushed++;
          end
        end
        4: begin
          v[1] = 1'b0;
          wb_wr(AdrCt, v, 4'hF);
          rxen_m = v[0];
        end
        default: begin
          wb_wr(AdrSt, v, 4'hF);
          if (v[5]) ovr_m = 1'b0;
        end
      endcase
      idle(2);
      check("rand irq", 32'(irq), 32'((rxen_m && rx_m.size() != 0) || ovr_m));
    end
    for (int i = 0; i < 3000 && got.size() < pushed; i++) idle(1);
    check("rand tx count", 32'(got.size()), 32'(pushed));
    for (int i = 0; i < tx_m.size() && i < got.size(); i++)
      check($sformatf("rand tx byte %0d", i), 32'(got[i]), 32'(tx_m[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
